// File: rtl/inst_mem_loader.sv
// Packs a framed big-endian byte stream into 32-bit words for instruction memory; write strobe one cycle after a word's 4th byte.
// byteReady depends only on registered state (low in IDLE/WRITE/DONE), so a stalled source simply holds its byte.
module inst_mem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_IML,
  input  logic              rst_IML_n,
  input  logic              start_IML,
  input  logic              byteValid_IML,
  input  logic [7:0]        byteData_IML,
  output logic              byteReady_IML,
  output logic              memWrite_IML,
  output logic [ADDR_W-1:0] memWrAddr_IML,
  output logic [DATA_W-1:0] memWrData_IML,
  output logic              cpuHold_IML,
  output logic              done_IML,
  output logic              error_IML,
  output logic [7:0]        wordCount_IML
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHK, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          rem_q, rem_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                write_q, write_d;
  logic                done_q, done_d;
  logic                hold_q, hold_d;
  logic                accept;

  assign accept = byteValid_IML && ready_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    csum_d  = csum_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_IML) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) begin
          csum_d = byteData_IML;
          rem_d  = byteData_IML;
          addr_d = BASE_ADDR;
          cnt_d  = 8'd0;
          idx_d  = 2'd0;
          if (byteData_IML == 8'd0) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[DATA_W-9:0], byteData_IML};
          csum_d = csum_q ^ byteData_IML;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        cnt_d   = cnt_q + 8'd1;
        rem_d   = rem_q - 8'd1;
        state_d = (rem_q == 8'd1) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (accept) begin
          err_d   = (byteData_IML != csum_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A new start clears the previous verdict and re-freezes the CPU on the same edge.
        if (start_IML) begin
          state_d = S_HDR;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
    write_d = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    hold_d  = !((state_d == S_DONE) && !err_d);
  end

  always_ff @(posedge clk_IML or negedge rst_IML_n) begin
    if (!rst_IML_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
      csum_q  <= 8'd0;
      rem_q   <= 8'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      write_q <= write_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  assign byteReady_IML = ready_q;
  assign memWrite_IML  = write_q;
  assign memWrAddr_IML = addr_q;
  assign memWrData_IML = word_q;
  assign cpuHold_IML   = hold_q;
  assign done_IML      = done_q;
  assign error_IML     = err_q;
  assign wordCount_IML = cnt_q;

endmodule
